// File: rtl/aes_pkg.sv
// Shared AES-128 types, constant tables and key-schedule helpers.
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  localparam int NR = 10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // One step of the AES-128 key schedule: previous round key -> next.
  function automatic block_t key_expand_step(input block_t rk, input logic [7:0] rcon);
    word_t t, w0, w1, w2, w3;
    t  = sub_word(rot_word(rk[31:0])) ^ {rcon, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  // One column slice per generate iteration; byte n lives at [127-8n -: 8],
  // column c holds bytes 4c..4c+3.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [3:0][7:0] sb;
    logic [31:0]     mix;
    logic [31:0]     col;

    // ShiftRows: row r of column c takes the byte from column (c+r)%4.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[r] = SBOX[state_i[127-8*(4*((c+r)%4)+r) -: 8]];
    end

    assign mix = {xtime(sb[0]) ^ xtime(sb[1]) ^ sb[1] ^ sb[2] ^ sb[3],
                  sb[0] ^ xtime(sb[1]) ^ xtime(sb[2]) ^ sb[2] ^ sb[3],
                  sb[0] ^ sb[1] ^ xtime(sb[2]) ^ xtime(sb[3]) ^ sb[3],
                  xtime(sb[0]) ^ sb[0] ^ sb[1] ^ sb[2] ^ xtime(sb[3])};

    assign col = final_i ? {sb[0], sb[1], sb[2], sb[3]} : mix;
    assign state_o[127-32*c -: 32] = col ^ rk_i[127-32*c -: 32];
  end

endmodule

// File: rtl/aes_128.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on the fly.
module aes_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bus,
  input  logic [127:0] key,
  output logic         out_valid,
  output logic [127:0] out_bus
);

  typedef enum logic {IDLE, BUSY} fsm_t;

  fsm_t        fsm_q, fsm_d;
  block_t      data_q, data_d;
  block_t      rk_q, rk_d;
  logic [3:0]  round_q, round_d;
  block_t      out_q, out_d;
  logic        ovld_q, ovld_d;

  logic [3:0]  rcon_idx;
  block_t      rk_next;
  block_t      round_out;
  logic        last_round;

  // round_q is 1..10 while busy; clamp the index so idle cycles never read past RCON.
  assign rcon_idx   = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
  assign rk_next    = key_expand_step(rk_q, RCON[rcon_idx]);
  assign last_round = (round_q == 4'(NR));

  aes_round u_round (
    .state_i (data_q),
    .rk_i    (rk_next),
    .final_i (last_round),
    .state_o (round_out)
  );

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = ovld_q;
  assign out_bus   = out_q;

  // Next-state: accept in IDLE, step one round per cycle in BUSY.
  always_comb begin
    fsm_d   = fsm_q;
    data_d  = data_q;
    rk_d    = rk_q;
    round_d = round_q;
    out_d   = out_q;
    ovld_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_bus ^ key;
          rk_d    = key;
          round_d = 4'd1;
          fsm_d   = BUSY;
        end
      end
      BUSY: begin
        data_d  = round_out;
        rk_d    = rk_next;
        round_d = round_q + 4'd1;
        if (last_round) begin
          out_d   = round_out;
          ovld_d  = 1'b1;
          round_d = 4'd0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any block silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      data_q  <= '0;
      rk_q    <= '0;
      round_q <= '0;
      out_q   <= '0;
      ovld_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      data_q  <= data_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      out_q   <= out_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_aes_128.sv
// Directed FIPS-197 vector bench for aes_128.
module tb_aes_128;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_bus;
  logic [127:0] key;
  logic         out_valid;
  logic [127:0] out_bus;

  int passes = 0;
  int total  = 0;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_128 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .key       (key),
    .out_valid (out_valid),
    .out_bus   (out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called right after an accept edge. Steps until out_valid (bounded),
  // requiring in_ready to track out_valid (busy => neither), then checks
  // that the pulse lands on the 10th edge after accept and the result.
  task automatic wait_done(input string tag, input logic [127:0] exp);
    int n;
    bit rdy_ok;
    n = 1;
    rdy_ok = 1'b1;
    do begin
      step();
      n++;
      if (in_ready !== out_valid) rdy_ok = 1'b0;
    end while (out_valid !== 1'b1 && n < 40);
    chk1({tag, " ready-low-while-busy"}, rdy_ok, 1'b1);
    chk_int({tag, " accept-to-accept cycles"}, n, 11);
    chk128({tag, " ciphertext"}, out_bus, exp);
  endtask

  initial begin
    int pulses;
    bit stable;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bus   = '0;
    key      = '0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state and quiet idle.
    chk1("reset in_ready", in_ready, 1'b1);
    chk1("reset out_valid", out_valid, 1'b0);
    chk128("reset out_bus", out_bus, '0);
    pulses = 0;
    repeat (8) begin
      step();
      if (out_valid !== 1'b0) pulses++;
    end
    chk_int("idle no pulse", pulses, 0);
    chk128("idle out_bus", out_bus, '0);

    // App. C.1 single block.
    in_bus = PT_C1; key = KEY_C1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk1("c1 busy after accept", in_ready, 1'b0);
    wait_done("c1", CT_C1);
    step();
    chk1("c1 pulse one cycle", out_valid, 1'b0);

    // App. B single block.
    in_bus = PT_B; key = KEY_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done("appB", CT_B);
    step();

    // Back-to-back: zero, C.1, B with in_valid held high.
    in_bus = '0; key = '0; in_valid = 1'b1;
    step();
    in_bus = PT_C1; key = KEY_C1;
    wait_done("b2b zero", CT_Z);
    step();
    in_bus = PT_B; key = KEY_B;
    wait_done("b2b c1", CT_C1);
    step();
    in_valid = 1'b0;
    wait_done("b2b appB", CT_B);
    step();
    chk1("b2b idle after", in_ready, 1'b1);

    // Inputs scrambled while busy must not affect the result or be accepted.
    in_bus = PT_B; key = KEY_B; in_valid = 1'b1;
    step();
    in_bus = '1; key = '1;
    wait_done("scramble", CT_B);
    in_valid = 1'b0;
    step();
    chk1("scramble no second accept", in_ready, 1'b1);
    chk1("scramble no pulse", out_valid, 1'b0);
    chk128("scramble out_bus held", out_bus, CT_B);

    // Reset during round 5 of App. B aborts silently.
    in_bus = PT_B; key = KEY_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk1("abort in_ready", in_ready, 1'b1);
    chk1("abort out_valid", out_valid, 1'b0);
    chk128("abort out_bus", out_bus, '0);
    pulses = 0;
    repeat (15) begin
      step();
      if (out_valid !== 1'b0) pulses++;
    end
    chk_int("abort no pulse", pulses, 0);

    // Fresh C.1 after abort, then output must hold with no traffic.
    in_bus = PT_C1; key = KEY_C1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done("post-abort c1", CT_C1);
    stable = 1'b1;
    repeat (20) begin
      step();
      if (out_bus !== CT_C1 || out_valid !== 1'b0) stable = 1'b0;
    end
    chk1("out_bus stable 20 cycles", stable, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
